fe_seq_ctrl: RTL and testbench

// Sequencer for the frequency-estimator (fe) datapath. Per start request it latches

---
 rtl/fe_seq_ctrl_if.sv | 22 ++
 rtl/fe_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_fe_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fe_seq_ctrl_if.sv
// Sequencer-to-fe control bus: enable/valid/shadow config out, fo estimate back.
interface fe_seq_ctrl_if #(
    parameter int NBW_LAT = 10,
    parameter int NBW_FO  = 15
);
    logic               o_fe_valid;
    logic               o_fe_enable;
    logic               o_fe_subsampling;
    logic [NBW_LAT-1:0] o_fe_pipe_lat;
    logic               i_fe_fo_valid;
    logic [NBW_FO-1:0]  i_fe_fo_value;

    modport master (
        output o_fe_valid, o_fe_enable, o_fe_subsampling, o_fe_pipe_lat,
        input  i_fe_fo_valid, i_fe_fo_value
    );

    modport slave (
        input  o_fe_valid, o_fe_enable, o_fe_subsampling, o_fe_pipe_lat,
        output i_fe_fo_valid, i_fe_fo_value
    );
endinterface

// File: rtl/fe_seq_ctrl.sv
// Frequency-estimator sequencer: arm fe, gate N input blocks, wait out pipe latency, capture fo.
// Optional DRAIN watchdog enabled by defining FE_SEQ_TIMEOUT_EN.
module fe_seq_ctrl #(
    parameter int NBW_IN  = 9,
    parameter int NBW_FO  = NBW_IN + 6,
    parameter int NBW_BLK = 8,
    parameter int NBW_LAT = 10
`ifdef FE_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst_async_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [NBW_BLK-1:0] i_cfg_nblk,
    input  logic               i_cfg_subsampling,
    input  logic [NBW_LAT-1:0] i_cfg_pipe_lat,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    fe_seq_ctrl_if.master      fe,
    output logic               o_fo_valid,
    output logic [NBW_FO-1:0]  o_fo_value,
    output logic               o_busy,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [NBW_BLK-1:0] blk_cnt;
    logic [NBW_LAT-1:0] lat_cnt;
    logic               handshake;
    logic               fo_accept;

    // Combinational so the fe valid lines up with source data on the same cycle.
    assign fe.o_fe_valid = i_in_valid & o_in_ready;
    assign handshake     = fe.o_fe_valid;
    assign fo_accept     = (state == S_DRAIN) && (lat_cnt == '0) && fe.i_fe_fo_valid;

`ifdef FE_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            wd_limit;

    assign wd_limit = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    assign o_timeout = 1'b0;
`endif

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state               <= S_IDLE;
            blk_cnt             <= '0;
            lat_cnt             <= '0;
            o_in_ready          <= 1'b0;
            fe.o_fe_enable      <= 1'b0;
            fe.o_fe_subsampling <= 1'b0;
            fe.o_fe_pipe_lat    <= '0;
            o_fo_valid          <= 1'b0;
            o_fo_value          <= '0;
            o_busy              <= 1'b0;
`ifdef FE_SEQ_TIMEOUT_EN
            wd_cnt              <= '0;
            o_timeout           <= 1'b0;
`endif
        end else begin
            o_fo_valid <= 1'b0;
`ifdef FE_SEQ_TIMEOUT_EN
            o_timeout  <= 1'b0;
`endif
            if (i_abort && (state != S_IDLE)) begin
                state          <= S_IDLE;
                o_in_ready     <= 1'b0;
                fe.o_fe_enable <= 1'b0;
                o_busy         <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start && !i_abort && (i_cfg_nblk != '0)) begin
                            blk_cnt             <= i_cfg_nblk;
                            fe.o_fe_subsampling <= i_cfg_subsampling;
                            fe.o_fe_pipe_lat    <= i_cfg_pipe_lat;
                            fe.o_fe_enable      <= 1'b1;
                            o_busy              <= 1'b1;
                            state               <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        o_in_ready <= 1'b1;
                        state      <= S_FEED;
                    end
                    S_FEED: begin
                        if (handshake) begin
                            if (blk_cnt == NBW_BLK'(1)) begin
                                o_in_ready <= 1'b0;
                                lat_cnt    <= fe.o_fe_pipe_lat;
`ifdef FE_SEQ_TIMEOUT_EN
                                wd_cnt     <= '0;
`endif
                                state      <= S_DRAIN;
                            end else begin
                                blk_cnt <= blk_cnt - NBW_BLK'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (fo_accept) begin
                            o_fo_value <= fe.i_fe_fo_value;
                            o_fo_valid <= 1'b1;
                            state      <= S_DONE;
                        end else if (lat_cnt != '0) begin
                            lat_cnt <= lat_cnt - NBW_LAT'(1);
`ifdef FE_SEQ_TIMEOUT_EN
                        end else if (wd_limit) begin
                            o_timeout      <= 1'b1;
                            fe.o_fe_enable <= 1'b0;
                            o_busy         <= 1'b0;
                            state          <= S_IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + WD_W'(1);
`endif
                        end
                    end
                    S_DONE: begin
                        fe.o_fe_enable <= 1'b0;
                        o_busy         <= 1'b0;
                        state          <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fe_seq_ctrl.sv
// Scoreboard bench for fe_seq_ctrl: directed spec scenarios plus randomized estimates.
// Build with FE_SEQ_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT_CYC=16).
module tb_fe_seq_ctrl;
    localparam int NBW_FO  = 15;
    localparam int NBW_BLK = 8;
    localparam int NBW_LAT = 10;

    logic               clk = 1'b0;
    logic               rst_async_n;
    logic               i_start;
    logic               i_abort;
    logic [NBW_BLK-1:0] i_cfg_nblk;
    logic               i_cfg_subsampling;
    logic [NBW_LAT-1:0] i_cfg_pipe_lat;
    logic               i_in_valid;
    logic               o_in_ready;
    logic               o_fo_valid;
    logic [NBW_FO-1:0]  o_fo_value;
    logic               o_busy;
    logic               o_timeout;

    fe_seq_ctrl_if #(.NBW_LAT(NBW_LAT), .NBW_FO(NBW_FO)) fe_if ();

`ifdef FE_SEQ_TIMEOUT_EN
    fe_seq_ctrl #(.TIMEOUT_CYC(16)) dut (
`else
    fe_seq_ctrl dut (
`endif
        .clk               (clk),
        .rst_async_n       (rst_async_n),
        .i_start           (i_start),
        .i_abort           (i_abort),
        .i_cfg_nblk        (i_cfg_nblk),
        .i_cfg_subsampling (i_cfg_subsampling),
        .i_cfg_pipe_lat    (i_cfg_pipe_lat),
        .i_in_valid        (i_in_valid),
        .o_in_ready        (o_in_ready),
        .fe                (fe_if.master),
        .o_fo_valid        (o_fo_valid),
        .o_fo_value        (o_fo_value),
        .o_busy            (o_busy),
        .o_timeout         (o_timeout)
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                fe_valid_cnt = 0;
    logic [NBW_FO-1:0] exp_q[$];
    logic [NBW_FO-1:0] last_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts fe valid beats and scores every reported estimate.
    always @(negedge clk) begin
        if (rst_async_n) begin
            if (fe_if.o_fe_valid) fe_valid_cnt++;
            if (o_fo_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_fo_valid actual=1 expected=0 @%0t", $time);
                end else begin
                    check("sb_fo_value", 32'(o_fo_value), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int nblk, input bit sub, input int lat);
        i_start           = 1'b1;
        i_cfg_nblk        = NBW_BLK'(nblk);
        i_cfg_subsampling = sub;
        i_cfg_pipe_lat    = NBW_LAT'(lat);
        fe_valid_cnt      = 0;
        tick();
        i_start           = 1'b0;
        i_cfg_nblk        = NBW_BLK'($urandom);
        i_cfg_subsampling = 1'($urandom);
        i_cfg_pipe_lat    = NBW_LAT'($urandom);
        check("arm_busy", o_busy, 1);
        check("arm_enable", fe_if.o_fe_enable, 1);
        check("arm_ready", o_in_ready, 0);
    endtask

    // Feeds blocks until nblk handshakes; returns positioned in DRAIN cycle 0.
    task automatic do_feed(input int nblk, input bit cont);
        int hs  = 0;
        int cyc = 0;
        while (hs < nblk && cyc < 300) begin
            i_in_valid          = cont ? 1'b1 : 1'($urandom_range(0, 1));
            i_start             = 1'($urandom_range(0, 1));
            fe_if.i_fe_fo_valid = 1'($urandom_range(0, 1));
            fe_if.i_fe_fo_value = NBW_FO'($urandom);
            #1;
            if (i_in_valid && o_in_ready) hs++;
            tick();
            cyc++;
        end
        i_in_valid          = 1'b0;
        i_start             = 1'b0;
        fe_if.i_fe_fo_valid = 1'b0;
        if (hs < nblk) check("feed_budget", 32'(hs), 32'(nblk));
        #1;
        check("fe_valid_count", 32'(fe_valid_cnt), 32'(nblk));
    endtask

    task automatic do_drain(input int lat, input bit sub, input int unsigned stale_mask,
                            input int acc_k, input logic [NBW_FO-1:0] acc_val);
        for (int k = 0; k <= acc_k; k++) begin
            if (k == 0) begin
                check("shadow_pipe_lat", 32'(fe_if.o_fe_pipe_lat), 32'(lat));
                check("shadow_subsampling", fe_if.o_fe_subsampling, sub);
                check("drain_ready", o_in_ready, 0);
            end
            fe_if.i_fe_fo_valid = (k == acc_k) || (k < lat && k < 32 && stale_mask[k]);
            fe_if.i_fe_fo_value = (k == acc_k) ? acc_val : NBW_FO'($urandom);
            tick();
        end
        fe_if.i_fe_fo_valid = 1'b0;
    endtask

    // One complete estimate. Model: captured value is the first fo pulse at drain cycle >= pipe_lat.
    task automatic run_est(input int nblk, input bit sub, input int lat, input int unsigned stale_mask,
                           input int acc_k, input logic [NBW_FO-1:0] acc_val, input bit cont);
        exp_q.push_back(acc_val);
        do_start(nblk, sub, lat);
        do_feed(nblk, cont);
        do_drain(lat, sub, stale_mask, acc_k, acc_val);
        check("done_fo_valid", o_fo_valid, 1);
        check("done_enable", fe_if.o_fe_enable, 1);
        tick();
        check("post_busy", o_busy, 0);
        check("post_enable", fe_if.o_fe_enable, 0);
        check("post_fo_valid", o_fo_valid, 0);
        check("held_fo_value", 32'(o_fo_value), 32'(acc_val));
        last_val = acc_val;
    endtask

    initial begin
        rst_async_n         = 1'b0;
        i_start             = 1'b0;
        i_abort             = 1'b0;
        i_cfg_nblk          = '0;
        i_cfg_subsampling   = 1'b0;
        i_cfg_pipe_lat      = '0;
        i_in_valid          = 1'b0;
        fe_if.i_fe_fo_valid = 1'b0;
        fe_if.i_fe_fo_value = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_fo_value", 32'(o_fo_value), 0);
        check("rst_pipe_lat", 32'(fe_if.o_fe_pipe_lat), 0);
        check("rst_enable", fe_if.o_fe_enable, 0);
        @(negedge clk);
        rst_async_n = 1'b1;
        tick();

        // Basic: 2 blocks, pipe_lat 5, fo at drain cycle 5.
        run_est(2, 1'b1, 5, 0, 5, 15'h1A3, 1'b1);
        // Stale pulse at drain cycle 2 ignored, cycle 6 captured.
        run_est(1, 1'b0, 5, 32'h4, 6, 15'h2B5, 1'b1);
        // Zero latency: accept on first drain cycle.
        run_est(3, 1'b0, 0, 0, 0, 15'h0F0, 1'b0);

        // Start with nblk = 0 is ignored.
        i_start = 1'b1;
        i_cfg_nblk = '0;
        i_cfg_pipe_lat = NBW_LAT'(4);
        tick();
        i_start = 1'b0;
        check("nblk0_busy", o_busy, 0);
        check("nblk0_enable", fe_if.o_fe_enable, 0);
        tick();
        check("nblk0_busy_later", o_busy, 0);

        // Abort in FEED after one of three blocks.
        do_start(3, 1'b0, 7);
        i_in_valid = 1'b1;
        tick();
        tick();
        i_in_valid = 1'b0;
        i_abort    = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_feed_busy", o_busy, 0);
        check("abort_feed_enable", fe_if.o_fe_enable, 0);
        check("abort_feed_ready", o_in_ready, 0);
        check("abort_feed_blocks", 32'(fe_valid_cnt), 1);
        check("abort_feed_value", 32'(o_fo_value), 32'(last_val));
        repeat (3) tick();

        // Abort beats a capture in the same cycle.
        do_start(2, 1'b0, 4);
        do_feed(2, 1'b1);
        repeat (4) tick();
        fe_if.i_fe_fo_valid = 1'b1;
        fe_if.i_fe_fo_value = 15'h777;
        i_abort = 1'b1;
        tick();
        fe_if.i_fe_fo_valid = 1'b0;
        i_abort = 1'b0;
        check("abort_cap_busy", o_busy, 0);
        check("abort_cap_fo_valid", o_fo_valid, 0);
        check("abort_cap_value", 32'(o_fo_value), 32'(last_val));
        tick();

        // Asynchronous reset mid-DRAIN, then a normal restart.
        do_start(1, 1'b1, 8);
        do_feed(1, 1'b1);
        repeat (3) tick();
        rst_async_n = 1'b0;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_enable", fe_if.o_fe_enable, 0);
        check("arst_fo_value", 32'(o_fo_value), 0);
        check("arst_shadow_sub", fe_if.o_fe_subsampling, 0);
        check("arst_shadow_lat", 32'(fe_if.o_fe_pipe_lat), 0);
        check("arst_fe_valid", fe_if.o_fe_valid, 0);
        @(negedge clk);
        rst_async_n = 1'b1;
        tick();
        run_est(2, 1'b0, 3, 32'h2, 4, 15'h3C3, 1'b1);

        // Watchdog behaviour with no fo_valid after latency expiry.
        begin
            int t_k = -1;
            do_start(1, 1'b0, 3);
            do_feed(1, 1'b1);
`ifdef FE_SEQ_TIMEOUT_EN
            for (int k = 0; k < 60 && t_k < 0; k++) begin
                if (o_timeout) t_k = k;
                else tick();
            end
            check("timeout_cycle", 32'(t_k), 19);
            check("timeout_busy", o_busy, 0);
            check("timeout_value", 32'(o_fo_value), 32'(last_val));
            tick();
            check("timeout_pulse_len", o_timeout, 0);
`else
            repeat (40) tick();
            check("no_wd_busy", o_busy, 1);
            check("no_wd_timeout", o_timeout, 0);
            i_abort = 1'b1;
            tick();
            i_abort = 1'b0;
            check("no_wd_abort_busy", o_busy, 0);
            check("no_wd_value", 32'(o_fo_value), 32'(last_val));
`endif
        end

        // Randomized back-to-back estimates.
        for (int n = 0; n < 25; n++) begin
            int                nb  = $urandom_range(1, 4);
            int                lat = $urandom_range(0, 12);
            int unsigned       msk = $urandom & ((32'd1 << lat) - 1);
            int                ak  = lat + $urandom_range(0, 3);
            logic [NBW_FO-1:0] v   = NBW_FO'($urandom);
            run_est(nb, 1'($urandom), lat, msk, ak, v, 1'($urandom));
        end

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
